// File: rtl/note_voice_gen.sv
// note_voice_gen
//   Square-wave voice generator. Once per sample tick it advances an
//   attack/sustain/release envelope and the waveform phase for the selected
//   note. On the following cycle it scales the envelope by VOLUME and presents
//   the signed sample on a VALID/READY handshake.
// Ports
//   CLOCK_50      sole clock
//   RESET         asynchronous, active-high reset
//   NOTE[3:0]     0 / 13..15 = off, 1..12 = C5..B5
//   VOLUME[3:0]   linear gain, 0 = mute, 15 = 15/16
//   SAMPLE[15:0]  signed two's-complement sample
//   SAMPLE_VALID  SAMPLE holds an untransferred sample
//   SAMPLE_READY  consumer takes SAMPLE on a cycle with VALID && READY
//   ENV_STATE     0 IDLE, 1 ATTACK, 2 SUSTAIN, 3 RELEASE
//   OVERRUN       sticky flag: an untransferred sample was overwritten
module note_voice_gen #(
   parameter int unsigned SAMPLE_DIV   = 1042,
   parameter logic [15:0] ATTACK_STEP  = 16'd512,
   parameter logic [15:0] RELEASE_STEP = 16'd256,
   parameter logic [15:0] AMP_MAX      = 16'h7FFF
) (
   input  logic        CLOCK_50,
   input  logic        RESET,
   input  logic [3:0]  NOTE,
   input  logic [3:0]  VOLUME,
   output logic [15:0] SAMPLE,
   output logic        SAMPLE_VALID,
   input  logic        SAMPLE_READY,
   output logic [1:0]  ENV_STATE,
   output logic        OVERRUN
);

   localparam int unsigned CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ATTACK  = 2'd1,
      ST_SUSTAIN = 2'd2,
      ST_RELEASE = 2'd3
   } env_state_t;

   env_state_t       state, state_nx;
   logic [CNT_W-1:0] tick_cnt;
   logic             tick, load;
   logic [15:0]      env, env_nx;
   logic [5:0]       hp_cnt, hp_nx;
   logic [5:0]       half, half_nx, note_half;
   logic             pol, pol_nx;
   logic             note_active;
   logic [16:0]      env_up, env_dn;
   logic             env_at_max, env_at_zero;
   logic [19:0]      prod;
   logic [15:0]      amp, sample_nx;

   assign tick        = (tick_cnt == CNT_W'(SAMPLE_DIV - 1));
   assign note_active = (NOTE >= 4'd1) && (NOTE <= 4'd12);

   // Half-period in samples for C5..B5
   always_comb begin
      note_half = '0;
      case (NOTE)
         4'd1:    note_half = 6'd46;
         4'd2:    note_half = 6'd43;
         4'd3:    note_half = 6'd41;
         4'd4:    note_half = 6'd39;
         4'd5:    note_half = 6'd36;
         4'd6:    note_half = 6'd34;
         4'd7:    note_half = 6'd32;
         4'd8:    note_half = 6'd31;
         4'd9:    note_half = 6'd29;
         4'd10:   note_half = 6'd27;
         4'd11:   note_half = 6'd26;
         4'd12:   note_half = 6'd24;
         default: note_half = '0;
      endcase
   end

   // 17-bit sum/difference so the ceiling and floor are detected without wrap
   assign env_up      = {1'b0, env} + {1'b0, ATTACK_STEP};
   assign env_dn      = {1'b0, env} - {1'b0, RELEASE_STEP};
   assign env_at_max  = (env_up >= {1'b0, AMP_MAX});
   assign env_at_zero = env_dn[16] || (env_dn[15:0] == 16'd0);

   always_comb begin
      state_nx = state;
      env_nx   = env;
      hp_nx    = hp_cnt;
      pol_nx   = pol;
      half_nx  = half;
      if (tick) begin
         if (note_active)
            half_nx = note_half;
         // ">=" rather than "==" so a switch to a shorter period mid-note
         // flips on the next tick instead of counting past the new limit
         if (state != ST_IDLE) begin
            if (({1'b0, hp_cnt} + 7'd1) >= {1'b0, half}) begin
               pol_nx = ~pol;
               hp_nx  = '0;
            end else begin
               hp_nx = hp_cnt + 6'd1;
            end
         end
         case (state)
            ST_IDLE: begin
               env_nx = '0;
               if (note_active) begin
                  state_nx = ST_ATTACK;
                  hp_nx    = '0;
                  pol_nx   = 1'b0;
               end
            end
            ST_ATTACK: begin
               env_nx = env_at_max ? AMP_MAX : env_up[15:0];
               if (!note_active)
                  state_nx = ST_RELEASE;
               else if (env_at_max)
                  state_nx = ST_SUSTAIN;
            end
            ST_SUSTAIN: begin
               env_nx = AMP_MAX;
               if (!note_active)
                  state_nx = ST_RELEASE;
            end
            ST_RELEASE: begin
               env_nx = env_at_zero ? 16'd0 : env_dn[15:0];
               if (note_active)
                  state_nx = ST_ATTACK;
               else if (env_at_zero)
                  state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
         endcase
      end
   end

   // Second pipeline stage works from the envelope/phase/state just updated
   assign prod      = 20'(env) * 20'(VOLUME);
   assign amp       = 16'(prod >> 4);
   assign sample_nx = (state == ST_IDLE) ? 16'd0 : (pol ? (16'd0 - amp) : amp);

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         tick_cnt     <= '0;
         load         <= 1'b0;
         state        <= ST_IDLE;
         env          <= '0;
         hp_cnt       <= '0;
         half         <= '0;
         pol          <= 1'b0;
         SAMPLE       <= '0;
         SAMPLE_VALID <= 1'b0;
         OVERRUN      <= 1'b0;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
         load     <= tick;
         state    <= state_nx;
         env      <= env_nx;
         hp_cnt   <= hp_nx;
         half     <= half_nx;
         pol      <= pol_nx;
         if (load) begin
            SAMPLE       <= sample_nx;
            SAMPLE_VALID <= 1'b1;
            if (SAMPLE_VALID && !SAMPLE_READY)
               OVERRUN <= 1'b1;
         end else if (SAMPLE_VALID && SAMPLE_READY) begin
            SAMPLE_VALID <= 1'b0;
         end
      end
   end

   assign ENV_STATE = state;

endmodule

// File: tb/tb_note_voice_gen.sv
module tb_note_voice_gen;

   localparam int DIV     = 8;
   localparam int ATT     = 512;
   localparam int REL     = 256;
   localparam int AMPMAX  = 32767;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  note = 4'd0;
   logic [3:0]  vol = 4'd15;
   logic        ready = 1'b1;
   logic [15:0] sample;
   logic        valid;
   logic [1:0]  env_st;
   logic        ovr;

   always #5 clk = ~clk;

   note_voice_gen #(
      .SAMPLE_DIV  (DIV),
      .ATTACK_STEP (16'(ATT)),
      .RELEASE_STEP(16'(REL)),
      .AMP_MAX     (16'h7FFF)
   ) dut (
      .CLOCK_50    (clk),
      .RESET       (rst),
      .NOTE        (note),
      .VOLUME      (vol),
      .SAMPLE      (sample),
      .SAMPLE_VALID(valid),
      .SAMPLE_READY(ready),
      .ENV_STATE   (env_st),
      .OVERRUN     (ovr)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference ----------------
   int half_tab[16] = '{0, 46, 43, 41, 39, 36, 34, 32, 31, 29, 27, 26, 24, 0, 0, 0};
   int m_cnt = 0, m_env = 0, m_state = 0, m_pol = 0, m_hp = 0, m_half = 0;
   int m_sample = 0, m_valid = 0, m_ovr = 0, m_amp = 0;
   bit m_pend = 0, m_loaded = 0;

   function automatic bit is_on(input int n);
      return (n >= 1) && (n <= 12);
   endfunction

   task automatic model_tick();
      int  h;
      bit  on;
      h  = m_half;
      on = is_on(int'(note));
      if (on) m_half = half_tab[note];
      if (m_state != 0) begin
         if (m_hp >= h - 1) begin
            m_pol = 1 - m_pol;
            m_hp  = 0;
         end else begin
            m_hp = m_hp + 1;
         end
      end
      case (m_state)
         0: begin
            m_env = 0;
            if (on) begin m_state = 1; m_hp = 0; m_pol = 0; end
         end
         1: begin
            m_env = m_env + ATT;
            if (m_env >= AMPMAX) begin
               m_env = AMPMAX;
               m_state = on ? 2 : 3;
            end else if (!on) begin
               m_state = 3;
            end
         end
         2: begin
            m_env = AMPMAX;
            if (!on) m_state = 3;
         end
         default: begin
            m_env = m_env - REL;
            if (m_env < 0) m_env = 0;
            if (on) m_state = 1;
            else if (m_env == 0) m_state = 0;
         end
      endcase
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      m_loaded = 0;
      if (rst) begin
         m_cnt = 0; m_env = 0; m_state = 0; m_pol = 0; m_hp = 0; m_half = 0;
         m_sample = 0; m_valid = 0; m_ovr = 0; m_pend = 0;
      end else begin
         if (m_pend) begin
            m_amp = (m_env * int'(vol)) / 16;
            if (m_valid == 1 && !ready) m_ovr = 1;
            m_sample = (m_state == 0) ? 0 : (m_pol == 1 ? -m_amp : m_amp);
            m_valid  = 1;
            m_loaded = 1;
         end else if (m_valid == 1 && ready) begin
            m_valid = 0;
         end
         m_pend = (m_cnt == DIV - 1);
         if (m_pend) model_tick();
         m_cnt = (m_cnt + 1) % DIV;
      end
   end

   // Every-cycle comparison against the reference
   initial forever begin
      @(negedge clk);
      check("sample", int'($signed(sample)), m_sample);
      check("valid", int'(valid), m_valid);
      check("env_state", int'(env_st), m_state);
      check("overrun", int'(ovr), m_ovr);
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_load();
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!m_loaded && k < 100);
      if (!m_loaded) check("wait_load_timeout", 0, 1);
   endtask

   task automatic wait_state(input int st, input int max_loads, input string name);
      int n;
      n = 0;
      while (int'(env_st) != st && n < max_loads) begin
         wait_load();
         n++;
      end
      check(name, int'(env_st), st);
   endtask

   task automatic count_edges_to_valid(input string name);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!valid && n < 50);
      check(name, n, DIV + 1);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int n;
      int r;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_sample", int'(sample), 0);
      check("rst_valid", int'(valid), 0);
      check("rst_env", int'(env_st), 0);
      check("rst_ovr", int'(ovr), 0);
      rst = 1'b0;
      count_edges_to_valid("first_tick_latency");

      // Off code from IDLE stays IDLE
      @(negedge clk);
      note = 4'd13;
      repeat (3) wait_load();
      check("note13_env", int'(env_st), 0);
      check("note13_sample", int'($signed(sample)), 0);

      // Attack from IDLE, NOTE=1, full volume
      note = 4'd1;
      vol  = 4'd15;
      wait_state(1, 20, "attack_entry_state");
      check("attack_entry_sample", int'($signed(sample)), 0);
      wait_load();
      check("attack_first_amp", int'($signed(sample)), 480);
      n = 1;
      while (env_st == 2'd1 && n < 200) begin
         wait_load();
         n++;
      end
      check("attack_ticks_to_sustain", n, 64);
      check("sustain_state", int'(env_st), 2);
      // 46 positive samples then negative: tick 64 falls in the negative half
      check("sustain_amp", int'($signed(sample)), -30719);

      // Release from sustain
      wait_load();
      note = 4'd0;
      wait_state(3, 10, "release_entry_state");
      r = 0;
      while (env_st == 2'd3 && r < 300) begin
         r++;
         wait_load();
      end
      check("release_ticks", r, 128);
      check("release_idle_state", int'(env_st), 0);
      check("release_idle_sample", int'($signed(sample)), 0);
      wait_load();
      check("idle_valid_pulses", int'(valid), 1);

      // Overrun with READY low, then accept coinciding with a load
      note  = 4'd5;
      ready = 1'b0;
      repeat (3) wait_load();
      check("ovr_valid_held", int'(valid), 1);
      check("ovr_set", int'(ovr), 1);
      repeat (DIV - 1) @(negedge clk);
      ready = 1'b1;
      @(negedge clk);
      check("accept_on_load_valid", int'(valid), 1);
      check("accept_on_load_ovr", int'(ovr), 1);
      @(negedge clk);
      check("accept_drops_valid", int'(valid), 0);

      // Mute: envelope walks to SUSTAIN while samples stay zero
      note = 4'd0;
      wait_state(0, 300, "mute_pre_idle");
      vol  = 4'd0;
      note = 4'd5;
      wait_state(2, 200, "mute_sustain_state");
      check("mute_sample", int'($signed(sample)), 0);

      // Randomised traffic
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 119) == 0) begin
            note = 4'($urandom_range(0, 15));
            vol  = 4'($urandom_range(0, 15));
         end
      end

      // Asynchronous reset mid-attack
      @(negedge clk);
      ready = 1'b1;
      vol   = 4'd9;
      note  = 4'd0;
      wait_state(0, 300, "arst_pre_idle");
      note = 4'd3;
      wait_state(1, 20, "arst_attack_entry");
      repeat (4) wait_load();
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_sample", int'(sample), 0);
      check("arst_valid", int'(valid), 0);
      check("arst_env", int'(env_st), 0);
      check("arst_ovr", int'(ovr), 0);
      #11 rst = 1'b0;
      count_edges_to_valid("arst_first_tick_latency");

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
